// File: rtl/synfull_endpoint_adapter_pkg.sv
// Shared types for the SynFull endpoint adapter: DPI request/deliver records, NoC flit format,
// FSM state encodings and the request-size clamp.
package synfull_endpoint_adapter_pkg;

  localparam int unsigned NumEp   = 16;
  localparam int unsigned DSTw    = $clog2(NumEp);
  localparam int unsigned MaxSize = 16;
  localparam int unsigned SIZEw   = $clog2(MaxSize + 1);

  typedef struct packed {
    logic [DSTw-1:0] dest;
    logic [31:0]     size;
    logic [DSTw-1:0] src;
    logic [31:0]     id;
    logic            valid;
  } req_t;

  typedef struct packed {
    logic [31:0] id;
    logic        valid;
  } deliver_t;

  typedef struct packed {
    logic             hdr;
    logic             tail;
    logic [DSTw-1:0]  src;
    logic [DSTw-1:0]  dest;
    logic [SIZEw-1:0] size;
    logic [31:0]      id;
  } synfull_flit_t;

  typedef struct packed {
    logic [DSTw-1:0]  dest;
    logic [SIZEw-1:0] size;
    logic [31:0]      id;
  } req_entry_t;

  typedef enum logic [1:0] {TxIdle, TxHead, TxBody} tx_state_t;
  typedef enum logic {RxWaitHead, RxCollect} rx_state_t;

  // A zero-length request still costs one flit; oversize requests are truncated.
  function automatic logic [SIZEw-1:0] clamp_size(input logic [31:0] size,
                                                  input int unsigned max_size);
    if (size == 32'd0) begin
      return SIZEw'(1);
    end else if (size > max_size) begin
      return SIZEw'(max_size);
    end else begin
      return SIZEw'(size);
    end
  endfunction

endpackage

// File: rtl/synfull_endpoint_adapter_req_fifo.sv
// Synchronous first-word-fall-through request FIFO; power-of-two depth so pointers wrap for free.
module synfull_endpoint_adapter_req_fifo
  import synfull_endpoint_adapter_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  req_entry_t      wdata_i,
  input  logic            pop_i,
  output req_entry_t      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  req_entry_t      r_mem [Depth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end

endmodule

// File: rtl/synfull_endpoint_adapter.sv
// NoC endpoint adapter: buffers DPI requests, serialises them into head/body/tail packets and
// reassembles ejected packets into one-cycle delivery reports.
module synfull_endpoint_adapter
  import synfull_endpoint_adapter_pkg::*;
#(
  parameter int unsigned EP_ID     = 0,
  parameter int unsigned NE        = NumEp,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned MAX_SIZE  = MaxSize
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  req_t          req_i,
  output logic          ready_o,
  output deliver_t      deliver_o,
  output synfull_flit_t tx_flit_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  input  synfull_flit_t rx_flit_i,
  input  logic          rx_valid_i,
  output logic          err_o
);

  localparam int unsigned FifoCntW = $clog2(REQ_DEPTH + 1);
  localparam logic [DSTw-1:0] EpId = DSTw'(EP_ID % NE);

  req_entry_t          w_entry;
  req_entry_t          w_head;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [FifoCntW-1:0] w_count;
  logic                w_unused;

  assign ready_o  = (w_count != FifoCntW'(REQ_DEPTH));
  assign w_push   = req_i.valid & ready_o;
  assign w_entry  = '{dest: req_i.dest, size: clamp_size(req_i.size, MAX_SIZE), id: req_i.id};
  assign w_unused = ^{req_i.src, w_full};

  synfull_endpoint_adapter_req_fifo #(
    .Depth (REQ_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .wdata_i (w_entry),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  tx_state_t        r_tx_state, w_tx_state_d;
  logic [SIZEw-1:0] r_tx_rem, w_tx_rem_d;
  req_entry_t       r_tx_pkt, w_tx_pkt_d;

  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_rem_d   = r_tx_rem;
    w_tx_pkt_d   = r_tx_pkt;
    w_pop        = 1'b0;
    tx_valid_o   = 1'b0;
    tx_flit_o    = '0;
    unique case (r_tx_state)
      TxIdle: begin
        if (!w_empty) w_tx_state_d = TxHead;
      end
      TxHead: begin
        tx_valid_o = 1'b1;
        tx_flit_o  = '{hdr: 1'b1, tail: (w_head.size == SIZEw'(1)), src: EpId,
                       dest: w_head.dest, size: w_head.size, id: w_head.id};
        if (tx_ready_i) begin
          w_pop      = 1'b1;
          w_tx_pkt_d = w_head;
          if (w_head.size == SIZEw'(1)) begin
            w_tx_state_d = TxIdle;
          end else begin
            w_tx_state_d = TxBody;
            w_tx_rem_d   = w_head.size - SIZEw'(1);
          end
        end
      end
      TxBody: begin
        tx_valid_o = 1'b1;
        tx_flit_o  = '{hdr: 1'b0, tail: (r_tx_rem == SIZEw'(1)), src: EpId,
                       dest: r_tx_pkt.dest, size: r_tx_pkt.size, id: r_tx_pkt.id};
        if (tx_ready_i) begin
          w_tx_rem_d = r_tx_rem - SIZEw'(1);
          if (r_tx_rem == SIZEw'(1)) w_tx_state_d = TxIdle;
        end
      end
      default: w_tx_state_d = TxIdle;
    endcase
  end

  rx_state_t        r_rx_state, w_rx_state_d;
  logic [31:0]      r_rx_id, w_rx_id_d;
  logic [SIZEw-1:0] r_rx_size, w_rx_size_d;
  logic [SIZEw-1:0] r_rcnt, w_rcnt_d;
  deliver_t         r_deliver, w_deliver_d;
  logic             r_err, w_err_d;

  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_id_d    = r_rx_id;
    w_rx_size_d  = r_rx_size;
    w_rcnt_d     = r_rcnt;
    w_deliver_d  = '0;
    w_err_d      = r_err;
    if (rx_valid_i) begin
      if (rx_flit_i.hdr) begin
        // A new head always wins; any packet still being collected is abandoned.
        if (r_rx_state == RxCollect) w_err_d = 1'b1;
        if (rx_flit_i.dest != EpId) begin
          w_err_d      = 1'b1;
          w_rx_state_d = RxWaitHead;
        end else begin
          w_rx_id_d   = rx_flit_i.id;
          w_rx_size_d = rx_flit_i.size;
          w_rcnt_d    = SIZEw'(1);
          if (rx_flit_i.tail) begin
            w_deliver_d  = '{id: rx_flit_i.id, valid: 1'b1};
            w_rx_state_d = RxWaitHead;
          end else begin
            w_rx_state_d = RxCollect;
          end
        end
      end else if (r_rx_state == RxWaitHead) begin
        w_err_d = 1'b1;
      end else begin
        w_rcnt_d = r_rcnt + SIZEw'(1);
        if (rx_flit_i.id != r_rx_id) w_err_d = 1'b1;
        if (w_rcnt_d > r_rx_size)    w_err_d = 1'b1;
        if (rx_flit_i.tail) begin
          w_deliver_d  = '{id: r_rx_id, valid: 1'b1};
          w_rx_state_d = RxWaitHead;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= TxIdle;
      r_tx_rem   <= '0;
      r_tx_pkt   <= '0;
      r_rx_state <= RxWaitHead;
      r_rx_id    <= '0;
      r_rx_size  <= '0;
      r_rcnt     <= '0;
      r_deliver  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_tx_rem   <= w_tx_rem_d;
      r_tx_pkt   <= w_tx_pkt_d;
      r_rx_state <= w_rx_state_d;
      r_rx_id    <= w_rx_id_d;
      r_rx_size  <= w_rx_size_d;
      r_rcnt     <= w_rcnt_d;
      r_deliver  <= w_deliver_d;
      r_err      <= w_err_d;
    end
  end

  assign deliver_o = r_deliver;
  assign err_o     = r_err;

endmodule
